// File: rtl/bcd_display_scheduler_if.sv
// Signal bundle between the timer logic, the shared BCD converter and the
// display scheduler. The scheduler uses the slave side.
interface bcd_display_scheduler_if;
  logic [23:0] vals;
  logic [3:0]  blank;
  logic        upd_req;
  logic        busy;
  logic        upd_done;
  logic [5:0]  conv_bin;
  logic [7:0]  conv_bcd;
  logic        conv_err;
  logic [7:0]  an;
  logic [3:0]  digit;

  modport master (
    output vals, blank, upd_req, conv_bcd,
    input  busy, upd_done, conv_bin, conv_err, an, digit
  );

  modport slave (
    input  vals, blank, upd_req, conv_bcd,
    output busy, upd_done, conv_bin, conv_err, an, digit
  );
endinterface

// File: rtl/bcd_display_scheduler.sv
// Shares one binary-to-BCD converter among four 6-bit channels, commits the
// results atomically and scans them onto eight multiplexed seven-segment digits.
module bcd_display_scheduler #(
  parameter int CLK_DIV  = 100000,
  parameter bit LZ_BLANK = 1'b1
) (
  input logic clk,
  input logic reset,
  bcd_display_scheduler_if.slave bus
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t      state_r;
  logic [1:0]  ch_r;
  logic [5:0]  shadow_r [4];
  logic [7:0]  pend_r   [4];
  logic [7:0]  disp_r   [4];
  logic        busy_r;
  logic        upd_done_r;
  logic        conv_err_r;
  logic [5:0]  conv_bin_r;

  logic [CW-1:0] cnt_r;
  logic [2:0]    slot_r;
  logic [7:0]    an_r;
  logic [3:0]    digit_r;

  logic [1:0]  sel_ch_s;
  logic [3:0]  sel_nib_s;
  logic        sel_blank_s;
  logic [7:0]  sel_an_s;

  function automatic logic bcd_bad(input logic [7:0] bcd);
    return (bcd[7:4] > 4'd9) || (bcd[3:0] > 4'd9);
  endfunction

  // Conversion sequencer: latch, convert each channel in turn, commit at once.
  // conv_bin is registered one step ahead so it always reflects the current ch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      ch_r       <= 2'd0;
      busy_r     <= 1'b0;
      upd_done_r <= 1'b0;
      conv_err_r <= 1'b0;
      conv_bin_r <= 6'd0;
      for (int k = 0; k < 4; k++) begin
        shadow_r[k] <= 6'd0;
        pend_r[k]   <= 8'd0;
        disp_r[k]   <= 8'd0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.upd_req) begin
            for (int k = 0; k < 4; k++) begin
              shadow_r[k] <= bus.vals[6*k +: 6];
            end
            ch_r       <= 2'd0;
            conv_bin_r <= bus.vals[5:0];
            busy_r     <= 1'b1;
            state_r    <= CONV;
          end
        end
        CONV: begin
          pend_r[ch_r] <= bus.conv_bcd;
          if (bcd_bad(bus.conv_bcd)) begin
            conv_err_r <= 1'b1;
          end
          if (ch_r == 2'd3) begin
            conv_bin_r <= 6'd0;
            upd_done_r <= 1'b1;
            state_r    <= COMMIT;
          end else begin
            ch_r       <= ch_r + 2'd1;
            conv_bin_r <= shadow_r[ch_r + 2'd1];
          end
        end
        COMMIT: begin
          for (int k = 0; k < 4; k++) begin
            disp_r[k] <= pend_r[k];
          end
          busy_r     <= 1'b0;
          upd_done_r <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          busy_r     <= 1'b0;
          upd_done_r <= 1'b0;
          conv_bin_r <= 6'd0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  // Decode the slot about to be shown: channel, nibble and blanking.
  always_comb begin
    sel_ch_s    = slot_r[2:1];
    sel_nib_s   = slot_r[0] ? disp_r[sel_ch_s][7:4] : disp_r[sel_ch_s][3:0];
    sel_blank_s = bus.blank[sel_ch_s] | (LZ_BLANK & slot_r[0] & (sel_nib_s == 4'd0));
    if (sel_blank_s) begin
      sel_an_s = 8'hFF;
    end else begin
      sel_an_s = ~(8'd1 << slot_r);
    end
  end

  // Refresh timer: slot_r names the digit that the next wrap puts on display,
  // so the first wrap after reset lights digit 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r   <= '0;
      slot_r  <= 3'd0;
      an_r    <= 8'hFF;
      digit_r <= 4'd0;
    end else if (cnt_r == CW'(CLK_DIV - 1)) begin
      cnt_r   <= '0;
      slot_r  <= slot_r + 3'd1;
      an_r    <= sel_an_s;
      digit_r <= sel_nib_s;
    end else begin
      cnt_r   <= cnt_r + CW'(1);
    end
  end

  assign bus.busy     = busy_r;
  assign bus.upd_done = upd_done_r;
  assign bus.conv_bin = conv_bin_r;
  assign bus.conv_err = conv_err_r;
  assign bus.an       = an_r;
  assign bus.digit    = digit_r;

endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a timing-rule model.
module tb_bcd_display_scheduler;

  localparam int CLK_DIV = 4;
  localparam bit LZ      = 1'b1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  bit   bad_on = 1'b0;

  always #5 clk = ~clk;

  bcd_display_scheduler_if bus();

  bcd_display_scheduler #(.CLK_DIV(CLK_DIV), .LZ_BLANK(LZ)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Ideal converter; optionally corrupts the value 55 into the invalid 8'h0A.
  function automatic logic [7:0] conv_f(input logic [5:0] v, input bit bad);
    logic [7:0] r;
    int iv;
    iv = int'(v);
    r = {4'(iv / 10), 4'(iv % 10)};
    if (bad && v == 6'd55) r = 8'h0A;
    return r;
  endfunction

  always_comb bus.conv_bcd = conv_f(bus.conv_bin, bad_on);

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_cyc   = 0;
  int         m_req   = -1;   // cycle in which the accepted request was sampled
  int         m_ticks = 0;
  int         m_slots = 0;
  bit         m_on    = 1'b0;
  bit         m_err   = 1'b0;
  logic [5:0] m_sh   [4];
  logic [7:0] m_pend [4];
  logic [7:0] m_buf  [4];
  logic [7:0] m_an   = 8'hFF;
  logic [3:0] m_dig  = 4'd0;

  task automatic model_step();
    int age, s, ch;
    logic [3:0] nib;
    logic [7:0] r;
    if (reset) begin
      m_req = -1; m_err = 1'b0; m_ticks = 0; m_slots = 0;
      m_an = 8'hFF; m_dig = 4'd0;
      for (int k = 0; k < 4; k++) m_buf[k] = 8'd0;
    end else begin
      if (m_ticks % CLK_DIV == CLK_DIV - 1) begin
        s   = m_slots % 8;
        ch  = s / 2;
        nib = (s % 2 == 1) ? m_buf[ch][7:4] : m_buf[ch][3:0];
        m_dig = nib;
        m_an  = (bus.blank[ch] || (LZ && s % 2 == 1 && nib == 4'd0)) ? 8'hFF : ~(8'h01 << s);
        m_slots++;
      end
      m_ticks++;
      if (m_req >= 0) begin
        age = m_cyc - m_req;
        if (age >= 1 && age <= 4) begin
          r = conv_f(m_sh[age-1], bad_on);
          m_pend[age-1] = r;
          if (r[7:4] > 4'd9 || r[3:0] > 4'd9) m_err = 1'b1;
        end else if (age == 5) begin
          m_buf = m_pend;
          m_req = -1;
        end
      end else if (bus.upd_req) begin
        for (int k = 0; k < 4; k++) m_sh[k] = bus.vals[6*k +: 6];
        m_req = m_cyc;
      end
    end
    m_cyc++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    m_on = 1'b1;
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    int age;
    @(negedge clk);
    if (m_on) begin
      age = m_cyc - m_req;
      chk("busy",     32'(bus.busy),     32'(m_req >= 0));
      chk("upd_done", 32'(bus.upd_done), 32'(m_req >= 0 && age == 5));
      chk("conv_bin", 32'(bus.conv_bin), (m_req >= 0 && age <= 4) ? 32'(m_sh[age-1]) : 32'd0);
      chk("conv_err", 32'(bus.conv_err), 32'(m_err));
      chk("an",       32'(bus.an),       32'(m_an));
      chk("digit",    32'(bus.digit),    32'(m_dig));
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] exp_an  [8] = '{8'hFE, 8'hFF, 8'hFB, 8'hFF, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [3:0] exp_dig [8] = '{4'd0, 4'd0, 4'd9, 4'd0, 4'd2, 4'd4, 4'd3, 4'd6};

  function automatic bit just_wrapped();
    return (m_ticks > 0) && (m_ticks % CLK_DIV == 0);
  endfunction

  task automatic pulse_req(input logic [23:0] v);
    bus.vals = v;
    bus.upd_req = 1'b1;
    @(negedge clk);
    bus.upd_req = 1'b0;
  endtask

  initial begin
    int n;
    int sl;
    bus.vals = 24'd0; bus.blank = 4'd0; bus.upd_req = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // reset state and first scan slots
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err",  32'(bus.conv_err), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("rst_an", 32'(bus.an), 32'hFF);
      @(negedge clk);
    end
    chk("slot0_an",  32'(bus.an), 32'hFE);
    chk("slot0_dig", 32'(bus.digit), 32'd0);
    repeat (CLK_DIV) @(negedge clk);
    chk("slot1_lz_an", 32'(bus.an), 32'hFF);

    // single conversion of {63,42,9,0}
    pulse_req({6'd63, 6'd42, 6'd9, 6'd0});
    chk("seq_bin0", 32'(bus.conv_bin), 32'd0);
    chk("seq_busy", 32'(bus.busy), 32'd1);
    @(negedge clk); chk("seq_bin1", 32'(bus.conv_bin), 32'd9);
    @(negedge clk); chk("seq_bin2", 32'(bus.conv_bin), 32'd42);
    @(negedge clk); chk("seq_bin3", 32'(bus.conv_bin), 32'd63);
    @(negedge clk); chk("seq_done", 32'(bus.upd_done), 32'd1);
    chk("seq_busy5", 32'(bus.busy), 32'd1);
    @(negedge clk); chk("seq_done_off", 32'(bus.upd_done), 32'd0);
    chk("seq_busy_off", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 9 * CLK_DIV; i++) begin
      @(negedge clk);
      if (just_wrapped()) begin
        sl = (m_slots - 1) % 8;
        chk("scan_an",  32'(bus.an),    32'(exp_an[sl]));
        chk("scan_dig", 32'(bus.digit), 32'(exp_dig[sl]));
      end
    end

    // request re-asserted during CONV is ignored
    bus.vals = {6'd1, 6'd2, 6'd3, 6'd4};
    bus.upd_req = 1'b1;
    n = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (bus.upd_done) n++;
      if (i == 2) bus.upd_req = 1'b0;
    end
    chk("one_done", 32'(n), 32'd1);
    pulse_req({6'd5, 6'd17, 6'd33, 6'd50});
    chk("second_bin0", 32'(bus.conv_bin), 32'd50);
    repeat (4) @(negedge clk);
    chk("second_done", 32'(bus.upd_done), 32'd1);

    // channel 2 blanking, then release
    bus.blank = 4'b0100;
    for (int i = 0; i < 9 * CLK_DIV; i++) begin
      @(negedge clk);
      if (just_wrapped() && ((m_slots - 1) % 8 == 4 || (m_slots - 1) % 8 == 5))
        chk("blank_an", 32'(bus.an), 32'hFF);
    end
    bus.blank = 4'b0000;
    for (int i = 0; i < 9 * CLK_DIV; i++) begin
      @(negedge clk);
      if (just_wrapped() && (m_slots - 1) % 8 == 4) begin
        chk("unblank4_an",  32'(bus.an), 32'hEF);
        chk("unblank4_dig", 32'(bus.digit), 32'd7);
      end
      if (just_wrapped() && (m_slots - 1) % 8 == 5) begin
        chk("unblank5_an",  32'(bus.an), 32'hDF);
        chk("unblank5_dig", 32'(bus.digit), 32'd1);
      end
    end

    // converter error on channel 1 is sticky
    bad_on = 1'b1;
    pulse_req({6'd10, 6'd20, 6'd55, 6'd7});
    @(negedge clk); chk("err_before", 32'(bus.conv_err), 32'd0);
    @(negedge clk); chk("err_after",  32'(bus.conv_err), 32'd1);
    repeat (4) @(negedge clk);
    bad_on = 1'b0;
    pulse_req({6'd1, 6'd2, 6'd3, 6'd4});
    repeat (6) @(negedge clk);
    chk("err_sticky", 32'(bus.conv_err), 32'd1);

    // reset in the second CONV cycle aborts the sequence
    pulse_req({6'd11, 6'd22, 6'd33, 6'd44});
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.upd_done), 32'd0);
    chk("abort_err",  32'(bus.conv_err), 32'd0);
    repeat (8) @(negedge clk);
    pulse_req({6'd12, 6'd34, 6'd56, 6'd60});
    repeat (4) @(negedge clk);
    chk("after_abort_done", 32'(bus.upd_done), 32'd1);

    // held request retriggers back to back
    bus.upd_req = 1'b1;
    repeat (40) @(negedge clk);
    bus.upd_req = 1'b0;

    // randomized phase
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      bus.upd_req = ($urandom_range(3) == 0);
      if ($urandom_range(3) == 0) bus.vals = 24'($urandom);
      if ($urandom_range(15) == 0) bus.blank = 4'($urandom);
      if ($urandom_range(99) == 0) bad_on = ~bad_on;
      reset = ($urandom_range(199) == 0);
    end
    reset = 1'b0;
    bus.upd_req = 1'b0;
    repeat (10) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
